// File: rtl/idecode_stage.sv
// MIPS instruction-decode stage: decodes one instruction per transfer into the ID/EX register,
// inserting a single bubble on a load-use dependency against the held instruction.
module idecode_stage #(
    parameter int DATA_W    = 32,
    parameter int EN_SHIFT  = 1,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_imm,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [3:0]        Af,
    output logic              I,
    output logic              ALU_MUX_SEL,
    output logic [4:0]        Cad,
    output logic              GP_WE,
    output logic [1:0]        GP_MUX_SEL,
    output logic [3:0]        Bf,
    output logic              DM_WE,
    output logic [2:0]        Shift_type,
    output logic [1:0]        PC_MUX_Select,
    output logic              illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic [3:0] af;
        logic       i;
        logic       alu_mux_sel;
        logic [4:0] cad;
        logic       gp_we;
        logic [1:0] gp_mux_sel;
        logic [3:0] bf;
        logic       dm_we;
        logic [2:0] shift_type;
        logic [1:0] pc_mux_select;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            OP_LW: begin
                c.af = 4'b0010; c.i = 1'b1; c.alu_mux_sel = 1'b1;
                c.cad = instr[20:16]; c.gp_we = 1'b1; c.gp_mux_sel = 2'b01;
            end
            OP_SW: begin
                c.af = 4'b0010; c.i = 1'b1; c.alu_mux_sel = 1'b1; c.dm_we = 1'b1;
            end
            OP_ADDI: begin
                c.af = 4'b0010; c.i = 1'b1; c.alu_mux_sel = 1'b1;
                c.cad = instr[20:16]; c.gp_we = 1'b1;
            end
            OP_RTYPE: begin
                c.cad = instr[15:11]; c.gp_we = 1'b1;
                case (instr[5:0])
                    6'b100000: c.af = 4'b0010;
                    6'b100010: c.af = 4'b0110;
                    6'b100100: c.af = 4'b0000;
                    6'b100101: c.af = 4'b0001;
                    6'b101010: c.af = 4'b0111;
                    6'b000000, 6'b000010, 6'b000011: begin
                        if (EN_SHIFT != 0) begin
                            c.shift_type = (instr[1:0] == 2'b00) ? 3'b001 :
                                           (instr[1:0] == 2'b10) ? 3'b010 : 3'b011;
                            c.gp_mux_sel = 2'b10;
                        end else begin
                            c.illegal = 1'b1;
                        end
                    end
                    6'b001000: begin c.gp_we = 1'b0; c.pc_mux_select = 2'b11; end
                    default:   c.illegal = 1'b1;
                endcase
            end
            OP_J:   c.pc_mux_select = 2'b10;
            OP_JAL: begin
                c.cad = 5'd31; c.gp_we = 1'b1; c.gp_mux_sel = 2'b11; c.pc_mux_select = 2'b10;
            end
            OP_BEQ: begin c.bf = 4'b0001; c.pc_mux_select = 2'b01; end
            OP_BNE: begin c.bf = 4'b0010; c.pc_mux_select = 2'b01; end
            default: c.illegal = 1'b1;
        endcase
        if (c.illegal) begin
            c = '0;
            c.illegal = 1'b1;
        end
        // r0 is hardwired, so a write to it must never reach the register file
        if (c.cad == 5'd0) c.gp_we = 1'b0;
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
        logic signed [15:0] s;
        s = signed'(v);
        return DATA_W'(s);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---- p0: combinational decode of the presented instruction, hazard, handshake
    ctrl_t       ctrl_p0, ctrl_p1;
    logic        uses_rt_p0, hazard_p0;
    logic        vld_p1;
    logic [DATA_W-1:0] pc_p1, imm_p1;
    logic [4:0]  rs_p1, rt_p1;
    logic [CNT_W-1:0] stall_cnt_p1;

    assign ctrl_p0    = decode(in_instr);
    assign uses_rt_p0 = (in_instr[31:26] == OP_RTYPE) || (in_instr[31:26] == OP_SW) ||
                        (in_instr[31:26] == OP_BEQ)   || (in_instr[31:26] == OP_BNE);
    assign hazard_p0  = (HAZARD_EN != 0) && in_valid && vld_p1 &&
                        (ctrl_p1.gp_mux_sel == 2'b01) && (ctrl_p1.cad != 5'd0) &&
                        ((ctrl_p1.cad == in_instr[25:21]) ||
                         (uses_rt_p0 && (ctrl_p1.cad == in_instr[20:16])));
    assign in_ready   = !rst && !flush && !hazard_p0 && (!vld_p1 || out_ready);

    // ---- p1: ID/EX register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            ctrl_p1      <= '0;
            pc_p1        <= '0;
            imm_p1       <= '0;
            rs_p1        <= '0;
            rt_p1        <= '0;
            stall_cnt_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (in_valid && in_ready) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= ctrl_p0;
            pc_p1   <= in_pc;
            imm_p1  <= sext16(in_instr[15:0]);
            rs_p1   <= in_instr[25:21];
            rt_p1   <= in_instr[20:16];
        end else if (hazard_p0 && out_ready) begin
            vld_p1       <= 1'b0;
            ctrl_p1      <= '0;
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end else if (vld_p1 && out_ready) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end
    end

    assign out_valid     = vld_p1;
    assign out_pc        = pc_p1;
    assign out_imm       = imm_p1;
    assign out_rs        = rs_p1;
    assign out_rt        = rt_p1;
    assign Af            = ctrl_p1.af;
    assign I             = ctrl_p1.i;
    assign ALU_MUX_SEL   = ctrl_p1.alu_mux_sel;
    assign Cad           = ctrl_p1.cad;
    assign GP_WE         = ctrl_p1.gp_we;
    assign GP_MUX_SEL    = ctrl_p1.gp_mux_sel;
    assign Bf            = ctrl_p1.bf;
    assign DM_WE         = ctrl_p1.dm_we;
    assign Shift_type    = ctrl_p1.shift_type;
    assign PC_MUX_Select = ctrl_p1.pc_mux_select;
    assign illegal       = ctrl_p1.illegal;
    assign stall_cnt     = stall_cnt_p1;

endmodule
